mem_responder: RTL and testbench

- Memory-side responder for the core's two memory ports: port 1 (instruction fetch, read-only) and port 2 (data, read/write with byte mask).
- Holds a word-addressed storage array with a programmable response latency per request.
- Uses a valid/ready request and response handshake, so the core and its testbench can move from a zero-latency memory model to multi-cycle memory.
- Sits between core and the simulation top; replaces the combinational memory model.

---
 rtl/mem_responder_pkg.sv | 31 +++
 rtl/mem_responder_if.sv | 42 ++++
 rtl/mem_responder_fsm.sv | 82 ++++++++
 rtl/mem_responder.sv | 82 ++++++++
 tb/tb_mem_responder.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants, state encoding and helpers for the memory responder.
//   ISA_WIDTH       data/address width of both memory ports
//   MEM_MASK_WIDTH  byte enables per word (one per byte)
//   MEMR_CNT_WIDTH  latency counter width (LATENCY up to 15)
package mem_responder_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int MEM_MASK_WIDTH = ISA_WIDTH / 8;
    localparam int MEMR_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        MEMR_IDLE = 2'd0,
        MEMR_WAIT = 2'd1,
        MEMR_RESP = 2'd2
    } memr_state_e;

    // Replace only the bytes whose enable bit is set.
    function automatic logic [ISA_WIDTH-1:0] merge_bytes(
        input logic [ISA_WIDTH-1:0]      old_word,
        input logic [ISA_WIDTH-1:0]      new_word,
        input logic [MEM_MASK_WIDTH-1:0] mask
    );
        logic [ISA_WIDTH-1:0] r;
        r = old_word;
        for (int i = 0; i < MEM_MASK_WIDTH; i++) begin
            if (mask[i]) r[8*i +: 8] = new_word[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle for the two memory ports.
//   p1_*  instruction fetch port (read only)
//   p2_*  data port (read/write with byte mask)
// master = core side (drives requests, takes responses)
// slave  = memory side (mem_responder)
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic                      p1_req_valid;
    logic                      p1_req_ready;
    logic [ISA_WIDTH-1:0]      p1_addr;
    logic                      p1_resp_valid;
    logic                      p1_resp_ready;
    logic [ISA_WIDTH-1:0]      p1_rdata;
    logic                      p1_err;

    logic                      p2_req_valid;
    logic                      p2_req_ready;
    logic [ISA_WIDTH-1:0]      p2_addr;
    logic                      p2_w_en;
    logic [ISA_WIDTH-1:0]      p2_wdata;
    logic [MEM_MASK_WIDTH-1:0] p2_mask;
    logic                      p2_resp_valid;
    logic                      p2_resp_ready;
    logic [ISA_WIDTH-1:0]      p2_rdata;
    logic                      p2_err;

    modport master (
        output p1_req_valid, p1_addr, p1_resp_ready,
        input  p1_req_ready, p1_resp_valid, p1_rdata, p1_err,
        output p2_req_valid, p2_addr, p2_w_en, p2_wdata, p2_mask, p2_resp_ready,
        input  p2_req_ready, p2_resp_valid, p2_rdata, p2_err
    );

    modport slave (
        input  p1_req_valid, p1_addr, p1_resp_ready,
        output p1_req_ready, p1_resp_valid, p1_rdata, p1_err,
        input  p2_req_valid, p2_addr, p2_w_en, p2_wdata, p2_mask, p2_resp_ready,
        output p2_req_ready, p2_resp_valid, p2_rdata, p2_err
    );

endinterface

// File: rtl/mem_responder_fsm.sv
// Per-port handshake controller: accepts one request, waits LATENCY cycles,
// then holds the captured response until the requester takes it.
//   clk, rst               clock, synchronous active-high reset
//   req_valid / req_ready  request handshake
//   resp_valid / resp_ready response handshake
//   rdata_in, err_in       response payload, captured at acceptance
//   rdata, err             registered response payload
//   accept                 one-cycle pulse on the acceptance edge
//
// state     | meaning
// ----------+-----------------------------------------------
// MEMR_IDLE | ready for a request
// MEMR_WAIT | latency countdown, no new request accepted
// MEMR_RESP | response presented, held until resp_ready
module mem_resp_fsm
    import mem_responder_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    input  logic [ISA_WIDTH-1:0] rdata_in,
    input  logic                 err_in,
    output logic [ISA_WIDTH-1:0] rdata,
    output logic                 err,
    output logic                 accept
);

    localparam logic [MEMR_CNT_WIDTH-1:0] CNT_LOAD = MEMR_CNT_WIDTH'(LATENCY - 1);

    memr_state_e               state, state_nx;
    logic [MEMR_CNT_WIDTH-1:0] cnt, cnt_nx;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            MEMR_IDLE: begin
                req_ready = 1'b1;
                // Nothing is accepted while reset is held, so no write can slip in.
                if (req_valid && !rst) begin
                    accept   = 1'b1;
                    cnt_nx   = CNT_LOAD;
                    state_nx = (LATENCY == 1) ? MEMR_RESP : MEMR_WAIT;
                end
            end
            MEMR_WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == 1) state_nx = MEMR_RESP;
            end
            MEMR_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = MEMR_IDLE;
            end
            default: state_nx = MEMR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEMR_IDLE;
            cnt   <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                rdata <= rdata_in;
                err   <= err_in;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Two-port memory responder with programmable response latency.
//   clk, rst  clock, synchronous active-high reset
//   bus       mem_responder_if.slave: p1 fetch port, p2 data port
// Holds the word array, decodes byte addresses against BASE, and performs
// masked writes; each port's handshake lives in its own mem_resp_fsm.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int                   DEPTH   = 4096,
    parameter logic [ISA_WIDTH-1:0] BASE    = 32'h8000_0000,
    parameter int                   LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int                   IDXW = $clog2(DEPTH);
    localparam logic [ISA_WIDTH-1:0] SPAN = ISA_WIDTH'(4 * DEPTH);

    logic [ISA_WIDTH-1:0] mem [DEPTH];

    // Unsigned subtraction: addresses below BASE wrap to large offsets and fail the range test.
    logic [ISA_WIDTH-1:0] p1_off, p2_off;
    logic                 p1_in_range, p2_in_range;
    logic [IDXW-1:0]      p1_idx, p2_idx;
    logic [ISA_WIDTH-1:0] p1_rd_in, p2_rd_in;
    logic                 p1_w_en;
    logic                 p1_accept, p2_accept;
    logic                 unused_addr_bits;

    assign p1_w_en     = 1'b0;
    assign p1_off      = bus.p1_addr - BASE;
    assign p2_off      = bus.p2_addr - BASE;
    assign p1_in_range = p1_off < SPAN;
    assign p2_in_range = p2_off < SPAN;
    assign p1_idx      = p1_off[IDXW+1:2];
    assign p2_idx      = p2_off[IDXW+1:2];

    assign unused_addr_bits = ^{p1_off[1:0], p2_off[1:0],
                                p1_off[ISA_WIDTH-1:IDXW+2], p2_off[ISA_WIDTH-1:IDXW+2]};

    // Array read happens before the same-edge write lands, so a same-cycle
    // port-1 read of the word being written returns the old contents.
    assign p1_rd_in = (p1_in_range && !p1_w_en)     ? mem[p1_idx] : '0;
    assign p2_rd_in = (p2_in_range && !bus.p2_w_en) ? mem[p2_idx] : '0;

    always_ff @(posedge clk) begin
        if (p2_accept && bus.p2_w_en && p2_in_range) begin
            mem[p2_idx] <= merge_bytes(mem[p2_idx], bus.p2_wdata, bus.p2_mask);
        end
    end

    mem_resp_fsm #(.LATENCY(LATENCY)) u_p1_fsm (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (bus.p1_req_valid),
        .req_ready  (bus.p1_req_ready),
        .resp_valid (bus.p1_resp_valid),
        .resp_ready (bus.p1_resp_ready),
        .rdata_in   (p1_rd_in),
        .err_in     (!p1_in_range),
        .rdata      (bus.p1_rdata),
        .err        (bus.p1_err),
        .accept     (p1_accept)
    );

    mem_resp_fsm #(.LATENCY(LATENCY)) u_p2_fsm (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (bus.p2_req_valid),
        .req_ready  (bus.p2_req_ready),
        .resp_valid (bus.p2_resp_valid),
        .resp_ready (bus.p2_resp_ready),
        .rdata_in   (p2_rd_in),
        .err_in     (!p2_in_range),
        .rdata      (bus.p2_rdata),
        .err        (bus.p2_err),
        .accept     (p2_accept)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: drivers push expected responses,
// per-port monitors pop and compare when a response handshake completes.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_responder_if bus ();

    mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    logic p1_vld_d = 1'b0;
    logic p2_vld_d = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Port-1 monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.p1_resp_valid && !p1_vld_d) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL p1_unexpected_resp: got rdata %h with no pending request", bus.p1_rdata);
                end else begin
                    chk("p1_latency", 32'(cyc - q1[0].acc), 32'(LAT));
                end
            end
            if (bus.p1_resp_valid && bus.p1_resp_ready && q1.size() > 0) begin
                e1 = q1.pop_front();
                chk("p1_rdata", bus.p1_rdata, e1.rdata);
                chk("p1_err", 32'(bus.p1_err), 32'(e1.err));
            end
        end
        p1_vld_d = bus.p1_resp_valid;
    end

    // Port-2 monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.p2_resp_valid && !p2_vld_d) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL p2_unexpected_resp: got rdata %h with no pending request", bus.p2_rdata);
                end else begin
                    chk("p2_latency", 32'(cyc - q2[0].acc), 32'(LAT));
                end
            end
            if (bus.p2_resp_valid && bus.p2_resp_ready && q2.size() > 0) begin
                e2 = q2.pop_front();
                chk("p2_rdata", bus.p2_rdata, e2.rdata);
                chk("p2_err", 32'(bus.p2_err), 32'(e2.err));
            end
        end
        p2_vld_d = bus.p2_resp_valid;
    end

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic p1_req(input logic [31:0] addr, input logic [31:0] exp_rd,
                          input logic exp_err, input bit push, output int waits);
        waits = 0;
        bus.p1_req_valid = 1'b1;
        bus.p1_addr      = addr;
        @(negedge clk);
        while (!bus.p1_req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.p1_req_ready) begin
            checks++;
            errors++;
            $display("FAIL p1_accept_timeout: req_ready got 0 expected 1 within 50 cycles");
        end else if (push) begin
            q1.push_back('{exp_rd, exp_err, cyc});
        end
        @(posedge clk);
        #1;
        bus.p1_req_valid = 1'b0;
        bus.p1_addr      = '0;
    endtask

    task automatic p2_req(input logic [31:0] addr, input logic w_en, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [31:0] exp_rd,
                          input logic exp_err, input bit push);
        int waits = 0;
        bus.p2_req_valid = 1'b1;
        bus.p2_addr      = addr;
        bus.p2_w_en      = w_en;
        bus.p2_wdata     = wdata;
        bus.p2_mask      = mask;
        @(negedge clk);
        while (!bus.p2_req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.p2_req_ready) begin
            checks++;
            errors++;
            $display("FAIL p2_accept_timeout: req_ready got 0 expected 1 within 50 cycles");
        end else if (push) begin
            q2.push_back('{exp_rd, exp_err, cyc});
        end
        @(posedge clk);
        #1;
        bus.p2_req_valid = 1'b0;
        bus.p2_addr      = '0;
        bus.p2_w_en      = 1'b0;
        bus.p2_wdata     = '0;
        bus.p2_mask      = '0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q1.size() != 0 || q2.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending p1 %0d p2 %0d expected 0", q1.size(), q2.size());
            q1.delete();
            q2.delete();
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A = 32'h8000_0010;
    localparam logic [31:0] B = 32'h8000_0020;
    localparam logic [31:0] C = 32'h8000_0030;
    localparam logic [31:0] W0   = 32'h8000_0000;
    localparam logic [31:0] WTOP = 32'h8000_3FFC;
    localparam logic [31:0] OOR_LO = 32'h7FFF_FFFC;
    localparam logic [31:0] OOR_HI = 32'h8000_4000;

    initial begin
        int w;
        int t;
        bus.p1_req_valid  = 1'b0;
        bus.p1_addr       = '0;
        bus.p1_resp_ready = 1'b1;
        bus.p2_req_valid  = 1'b0;
        bus.p2_addr       = '0;
        bus.p2_w_en       = 1'b0;
        bus.p2_wdata      = '0;
        bus.p2_mask       = '0;
        bus.p2_resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        repeat (5) begin
            @(negedge clk);
            chk("rst_p1_req_ready", 32'(bus.p1_req_ready), 32'd1);
            chk("rst_p2_req_ready", 32'(bus.p2_req_ready), 32'd1);
            chk("rst_p1_resp_valid", 32'(bus.p1_resp_valid), 32'd0);
            chk("rst_p2_resp_valid", 32'(bus.p2_resp_valid), 32'd0);
            chk("rst_p1_rdata", bus.p1_rdata, 32'd0);
            chk("rst_p2_rdata", bus.p2_rdata, 32'd0);
            chk("rst_p1_err", 32'(bus.p1_err), 32'd0);
            chk("rst_p2_err", 32'(bus.p2_err), 32'd0);
        end
        @(posedge clk);
        #1;

        // Full write then read back on port 1 and port 2
        p2_req(A, 1'b1, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 1'b1);
        drain();
        p1_req(A, 32'hDEAD_BEEF, 1'b0, 1'b1, w);
        drain();

        // Masked writes
        p2_req(A, 1'b1, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 1'b1);
        drain();
        p1_req(A, 32'hDE22_BE44, 1'b0, 1'b1, w);
        drain();
        p2_req(A, 1'b1, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 1'b1);
        drain();
        p1_req(A, 32'hDE22_BE44, 1'b0, 1'b1, w);
        p2_req(A, 1'b0, 32'h0, 4'b0000, 32'hDE22_BE44, 1'b0, 1'b1);
        drain();

        // Same-cycle read and write to one word
        p2_req(B, 1'b1, 32'hAAAA_AAAA, 4'b1111, 32'h0, 1'b0, 1'b1);
        drain();
        fork
            p1_req(B, 32'hAAAA_AAAA, 1'b0, 1'b1, w);
            p2_req(B, 1'b1, 32'h5555_5555, 4'b1111, 32'h0, 1'b0, 1'b1);
        join
        drain();
        p1_req(B, 32'h5555_5555, 1'b0, 1'b1, w);
        drain();

        // Backpressure on port 1
        bus.p1_resp_ready = 1'b0;
        p1_req(A, 32'hDE22_BE44, 1'b0, 1'b1, w);
        t = 0;
        @(negedge clk);
        while (!bus.p1_resp_valid && t < 20) begin
            t++;
            @(negedge clk);
        end
        chk("bp_valid_seen", 32'(bus.p1_resp_valid), 32'd1);
        repeat (4) begin
            chk("bp_resp_valid", 32'(bus.p1_resp_valid), 32'd1);
            chk("bp_rdata", bus.p1_rdata, 32'hDE22_BE44);
            chk("bp_req_ready", 32'(bus.p1_req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.p1_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        p1_req(B, 32'h5555_5555, 1'b0, 1'b1, w);
        chk("bp_next_accept_waits", 32'(w), 32'd0);
        drain();

        // Out-of-range addresses
        p2_req(W0, 1'b1, 32'h0102_0304, 4'b1111, 32'h0, 1'b0, 1'b1);
        drain();
        p2_req(WTOP, 1'b1, 32'h0A0B_0C0D, 4'b1111, 32'h0, 1'b0, 1'b1);
        drain();
        p1_req(OOR_LO, 32'h0, 1'b1, 1'b1, w);
        p1_req(OOR_HI, 32'h0, 1'b1, 1'b1, w);
        p2_req(OOR_HI, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b1);
        drain();
        p2_req(OOR_HI, 1'b1, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1, 1'b1);
        drain();
        p2_req(OOR_LO, 1'b1, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1, 1'b1);
        drain();
        p1_req(W0, 32'h0102_0304, 1'b0, 1'b1, w);
        p1_req(WTOP, 32'h0A0B_0C0D, 1'b0, 1'b1, w);
        drain();

        // Reset while both ports are in WAIT
        fork
            p1_req(A, 32'h0, 1'b0, 1'b0, w);
            p2_req(C, 1'b1, 32'h7777_8888, 4'b1111, 32'h0, 1'b0, 1'b0);
        join
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstwait_p1_req_ready", 32'(bus.p1_req_ready), 32'd1);
        chk("rstwait_p2_req_ready", 32'(bus.p2_req_ready), 32'd1);
        repeat (4) begin
            chk("rstwait_p1_resp_valid", 32'(bus.p1_resp_valid), 32'd0);
            chk("rstwait_p2_resp_valid", 32'(bus.p2_resp_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        p1_req(C, 32'h7777_8888, 1'b0, 1'b1, w);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule
